// File: rtl/ysyx_24110015_ifu_if.sv
// ----------------------------------------------------------------------------
// ysyx_24110015_ifu_if
// Handshake bundle between the instruction-fetch unit and its neighbours.
//   Fetch request  : req_valid / req_ready / req_addr      (IFU -> memory)
//   Fetch response : rsp_valid / rsp_data                  (memory -> IFU)
//   Instruction    : inst_valid / inst_ready / inst / inst_pc (IFU -> IDU)
//   Redirect       : redirect / redirect_pc                (EXU -> IFU)
// Modports:
//   master : the IFU side
//   slave  : the environment side (memory, IDU, EXU)
// ----------------------------------------------------------------------------
interface ysyx_24110015_ifu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output req_valid, req_addr, inst_valid, inst, inst_pc,
        input  req_ready, rsp_valid, rsp_data, inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  req_valid, req_addr, inst_valid, inst, inst_pc,
        output req_ready, rsp_valid, rsp_data, inst_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/ysyx_24110015_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_24110015_ifu
// Decoupled instruction-fetch front end. Owns the fetch PC, issues pipelined
// in-order reads to instruction memory, buffers responses in a DEPTH-entry
// queue tagged with their PC, and hands them to the IDU. A redirect flushes
// the queue and silently discards responses still owed by memory.
// Ports:
//   clk      : clock, all state on rising edge
//   rst      : asynchronous active-high reset
//   bus      : request / response / instruction / redirect handshakes
//   inflight : requests accepted but not yet answered (including doomed ones)
// ----------------------------------------------------------------------------
module ysyx_24110015_ifu #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000,
    parameter int                DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_24110015_ifu_if.master          bus,
    output logic [$clog2(DEPTH+1)-1:0]   inflight
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [PTR_W-1:0]  alloc_ptr;
    logic [PTR_W-1:0]  fill_ptr;
    logic [PTR_W-1:0]  head_ptr;
    logic [CNT_W-1:0]  used;     // entries allocated and not yet popped
    logic [CNT_W-1:0]  drop;     // responses still to be discarded

    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  filled;

    logic req_valid_c;
    logic inst_valid_c;
    logic accept;
    logic pop;
    logic live_rsp;
    logic drop_rsp;

    always_comb begin
        req_valid_c  = !rst && !bus.redirect && (used < DEPTH_C) && (inflight < DEPTH_C);
        inst_valid_c = filled[head_ptr] && !bus.redirect;
        accept       = req_valid_c && bus.req_ready;
        pop          = inst_valid_c && bus.inst_ready;
        // A response in the redirect cycle belongs to the old stream; it is
        // accounted for by the drop value loaded in that same cycle.
        live_rsp     = bus.rsp_valid && !bus.redirect && (drop == '0);
        drop_rsp     = bus.rsp_valid && !bus.redirect && (drop != '0);
    end

    assign bus.req_valid  = req_valid_c;
    assign bus.req_addr   = fetch_pc;
    assign bus.inst_valid = inst_valid_c;
    assign bus.inst       = data_q[head_ptr];
    assign bus.inst_pc    = pc_q[head_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            used      <= '0;
            drop      <= '0;
            inflight  <= '0;
            filled    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // Memory owes one response per accept regardless of redirects.
            inflight <= inflight + CNT_W'(accept) - CNT_W'(bus.rsp_valid);

            if (bus.redirect) begin
                fetch_pc  <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
                alloc_ptr <= '0;
                fill_ptr  <= '0;
                head_ptr  <= '0;
                used      <= '0;
                filled    <= '0;
                drop      <= inflight - CNT_W'(bus.rsp_valid);
            end else begin
                // Accept, fill and pop always target distinct entries: the
                // alloc slot is free, the fill slot is allocated but unfilled,
                // and the head slot is filled whenever a pop occurs.
                if (accept) begin
                    fetch_pc          <= fetch_pc + ADDR_W'(4);
                    pc_q[alloc_ptr]   <= fetch_pc;
                    filled[alloc_ptr] <= 1'b0;
                    alloc_ptr         <= alloc_ptr + PTR_W'(1);
                end
                if (live_rsp) begin
                    data_q[fill_ptr] <= bus.rsp_data;
                    filled[fill_ptr] <= 1'b1;
                    fill_ptr         <= fill_ptr + PTR_W'(1);
                end
                if (drop_rsp) begin
                    drop <= drop - CNT_W'(1);
                end
                if (pop) begin
                    filled[head_ptr] <= 1'b0;
                    head_ptr         <= head_ptr + PTR_W'(1);
                end
                used <= used + CNT_W'(accept) - CNT_W'(pop);
            end
        end
    end
endmodule

// File: tb/tb_ysyx_24110015_ifu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_24110015_ifu
// Directed bench for the fetch unit. dut (RESET_PC 8000_0000) is driven by a
// fixed-latency in-order memory returning addr ^ A5A5_A5A5; dut2
// (RESET_PC FFFF_FFF8) exercises fetch-address wrap with memory always ready.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ----------------------------------------------------------------------------
module tb_ysyx_24110015_ifu;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] inflight1;
    logic [2:0] inflight2;

    ysyx_24110015_ifu_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    ysyx_24110015_ifu_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    ysyx_24110015_ifu #(
        .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h8000_0000), .DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus1), .inflight(inflight1)
    );

    ysyx_24110015_ifu #(
        .ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)
    ) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .inflight(inflight2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mrsp_t;
    mrsp_t mq[$];

    typedef struct {
        logic        rr;
        logic        ir;
        logic        rd;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] ea;
        logic        eiv;
        logic [31:0] epc;
        int          ein;
    } vec_t;
    vec_t vt [10];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic drive_idle();
        bus1.req_ready   = 1'b0;
        bus1.rsp_valid   = 1'b0;
        bus1.rsp_data    = '0;
        bus1.inst_ready  = 1'b0;
        bus1.redirect    = 1'b0;
        bus1.redirect_pc = '0;
        bus2.req_ready   = 1'b1;
        bus2.rsp_valid   = 1'b0;
        bus2.rsp_data    = '0;
        bus2.inst_ready  = 1'b0;
        bus2.redirect    = 1'b0;
        bus2.redirect_pc = '0;
    endtask

    // Assert reset (memory model cleared with it), check async reset values.
    task automatic do_reset(input int l);
        @(negedge clk);
        rst = 1'b1;
        lat = l;
        cyc = -1;
        drive_idle();
        mq.delete();
        #1;
        chk("rst_req_valid",  bus1.req_valid,  1'b0);
        chk("rst_req_addr",   bus1.req_addr,   32'h8000_0000);
        chk("rst_inst_valid", bus1.inst_valid, 1'b0);
        chk("rst_inst",       bus1.inst,       32'h0);
        chk("rst_inst_pc",    bus1.inst_pc,    32'h0);
        chk("rst_inflight",   inflight1,       3'd0);
        @(negedge clk);
    endtask

    // One cycle: apply inputs and the memory's response for this cycle.
    task automatic step(input logic rr, input logic ir, input logic rd, input logic [31:0] rpc);
        mrsp_t m;
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        bus1.req_ready   = rr;
        bus1.inst_ready  = ir;
        bus1.redirect    = rd;
        bus1.redirect_pc = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            bus1.rsp_valid = 1'b1;
            bus1.rsp_data  = m.data;
        end else begin
            bus1.rsp_valid = 1'b0;
            bus1.rsp_data  = '0;
        end
        #1;
        if (bus1.req_valid && bus1.req_ready) begin
            m.data = bus1.req_addr ^ KEY;
            m.due  = cyc + lat;
            mq.push_back(m);
        end
    endtask

    task automatic chk_inst(input string name, input logic [31:0] pc);
        chk({name, "_valid"}, bus1.inst_valid, 1'b1);
        chk({name, "_pc"},    bus1.inst_pc,    pc);
        chk({name, "_data"},  bus1.inst,       pc ^ KEY);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Full queue, DEPTH=4, 1-cycle memory, consumer stalled except cycle 6.
        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0000, 1'b0, 32'h0,          0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0004, 1'b0, 32'h0,          1};
        vt[2] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000, 1};
        vt[3] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0000, 1};
        vt[4] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h8000_0010, 1'b1, 32'h8000_0000, 1};
        vt[5] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h8000_0010, 1'b1, 32'h8000_0000, 0};
        vt[6] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h8000_0010, 1'b1, 32'h8000_0000, 0};
        vt[7] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0004, 0};
        vt[8] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h8000_0014, 1'b1, 32'h8000_0004, 1};
        vt[9] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h8000_0014, 1'b1, 32'h8000_0004, 0};

        drive_idle();

        // Reset and stream; dut2 checks address wrap in the same run.
        do_reset(1);
        chk("wrap_rst_addr", bus2.req_addr, 32'hFFFF_FFF8);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (k == 0) begin
                chk("first_req_valid", bus1.req_valid, 1'b1);
                chk("first_req_addr",  bus1.req_addr,  32'h8000_0000);
                chk("wrap_addr0",      bus2.req_addr,  32'hFFFF_FFF8);
            end
            if (k == 1) chk("wrap_addr1", bus2.req_addr, 32'hFFFF_FFFC);
            if (k == 2) chk("wrap_addr2", bus2.req_addr, 32'h0000_0000);
            if (k == 4) chk("wrap_full_req_valid", bus2.req_valid, 1'b0);
            if (k >= 1) chk("stream_inflight", inflight1, 3'd1);
            if (k >= 2) chk_inst("stream", 32'h8000_0000 + 32'(4 * (k - 2)));
        end

        // Full queue / back-pressure table.
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            step(vt[i].rr, vt[i].ir, vt[i].rd, vt[i].rpc);
            chk("fq_req_valid",  bus1.req_valid,  vt[i].ev);
            chk("fq_req_addr",   bus1.req_addr,   vt[i].ea);
            chk("fq_inst_valid", bus1.inst_valid, vt[i].eiv);
            if (vt[i].eiv) begin
                chk("fq_inst_pc", bus1.inst_pc, vt[i].epc);
                chk("fq_inst",    bus1.inst,    vt[i].epc ^ KEY);
            end
            chk("fq_inflight", inflight1, 3'(vt[i].ein));
        end

        // Redirect with two requests in flight, 3-cycle memory.
        do_reset(3);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h8000_0103);
        chk("rd_req_valid",  bus1.req_valid, 1'b0);
        chk("rd_inflight",   inflight1,      3'd2);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rd_new_valid",  bus1.req_valid, 1'b1);
        chk("rd_new_addr",   bus1.req_addr,  32'h8000_0100);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("rd_drop_iv4",   bus1.inst_valid, 1'b0);
        chk("rd_inflight4",  inflight1,       3'd2);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("rd_drop_iv5",   bus1.inst_valid, 1'b0);
        chk("rd_inflight5",  inflight1,       3'd1);
        chk("rd_stall_addr", bus1.req_addr,   32'h8000_0104);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("rd_drop_iv6",   bus1.inst_valid, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_inst("rd_first", 32'h8000_0100);
        chk("rd_idle_inflight", inflight1, 3'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("rd_after_pop_iv", bus1.inst_valid, 1'b0);

        // Redirect coinciding with a response and inst_ready=1.
        do_reset(1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h8000_0200);
        chk("rc_inst_valid", bus1.inst_valid, 1'b0);
        chk("rc_req_valid",  bus1.req_valid,  1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rc_new_addr",   bus1.req_addr,   32'h8000_0200);
        chk("rc_iv3",        bus1.inst_valid, 1'b0);
        chk("rc_inflight",   inflight1,       3'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("rc_iv4",        bus1.inst_valid, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_inst("rc_first", 32'h8000_0200);

        // Stalled request: req_ready low for 5 cycles.
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk("st_req_valid", bus1.req_valid, 1'b1);
            chk("st_req_addr",  bus1.req_addr,  32'h8000_0000);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("st_next_addr", bus1.req_addr, 32'h8000_0004);
        chk("st_inflight",  inflight1,     3'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_inst("st_first", 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
